mem_req_arbiter: RTL

// - Shares the memory controller's 16-entry request ring between two requesters (0 = icache miss, 1 = dcache miss/evict).
// - Round-robin grants; allocates a free 4-bit ring id per request and records which requester owns it.
// - Routes read-data and write-ack packets back to the owner, then frees the id.
// - Provides a drain sequence so the host can quiesce memory traffic before an MMIO base-address change.

---
 rtl/mem_req_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front end for the 16-id memory request ring, with id tracking and drain.
// Optional ARB_LINE_HAZARD_EN: stall a request whose line address matches any in-flight id.
module mem_req_arbiter #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 36,
    parameter int NUM_IDS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_data,
    output logic [1:0]             req_ready,
    output logic [1:0]             resp_valid,
    output logic                   resp_is_ack,
    output logic [DATA_W-1:0]      resp_data,
    output logic [2:0]             mc_type_out,
    output logic [3:0]             mc_id_out,
    output logic [ADDR_W-1:0]      mc_addr_out,
    output logic [DATA_W-1:0]      mc_data_out,
    input  logic [2:0]             mc_type_in,
    input  logic [3:0]             mc_id_in,
    input  logic [DATA_W-1:0]      mc_data_in,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic [4:0]             outstanding,
    output logic                   err_orphan
);
    // Handshake: a request transfers on a cycle where req_valid[i] and req_ready[i] are both high;
    // req_ready is combinational and never waits on req_valid of the same requester being held.

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t             state;
    logic               rr_ptr;
    logic [NUM_IDS-1:0] free_vec;
    logic [NUM_IDS-1:0] owner;

    logic [1:0]         cand;
    logic               grant_any;
    logic               grant_sel;
    logic [3:0]         alloc_id;
    logic [NUM_IDS-1:0] alloc_mask;
    logic [NUM_IDS-1:0] free_mask;
    logic [NUM_IDS-1:0] free_next;
    logic               resp_type_ok;
    logic               resp_hit;
    logic               resp_orphan;
    logic [4:0]         busy_cnt;

`ifdef ARB_LINE_HAZARD_EN
    logic [ADDR_W-1:0]  addr_tab [NUM_IDS];
    logic [1:0]         line_hit;

    always_comb begin
        line_hit = 2'b00;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < NUM_IDS; j++) begin
                if (!free_vec[j] && addr_tab[j] == req_addr[r]) line_hit[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_IDS; j++) addr_tab[j] <= '0;
        end else if (grant_any) begin
            addr_tab[alloc_id] <= req_addr[grant_sel];
        end
    end
`endif

    always_comb begin
`ifdef ARB_LINE_HAZARD_EN
        cand = req_valid & ~line_hit;
`else
        cand = req_valid;
`endif
        // The drain level gates grants in the same cycle so no request slips in behind it.
        grant_any = (state == ST_RUN) && !drain_req && (|free_vec) && (|cand);
        grant_sel = (cand == 2'b11) ? rr_ptr : cand[1];
        req_ready = 2'b00;
        if (grant_any) req_ready[grant_sel] = 1'b1;

        alloc_id = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_id = i[3:0];
        end
        alloc_mask = grant_any ? (NUM_IDS'(1) << alloc_id) : '0;

        resp_type_ok = (mc_type_in == 3'b101) || (mc_type_in == 3'b110);
        resp_hit     = resp_type_ok && !free_vec[mc_id_in];
        resp_orphan  = resp_type_ok && free_vec[mc_id_in];
        free_mask    = resp_hit ? (NUM_IDS'(1) << mc_id_in) : '0;
        free_next    = (free_vec & ~alloc_mask) | free_mask;

        busy_cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) busy_cnt = busy_cnt + {4'b0, ~free_next[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                ST_RUN: if (drain_req) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (outstanding == 5'd0) begin
                        state      <= ST_DONE;
                        drain_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!drain_req) begin
                        state      <= ST_RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            free_vec    <= '1;
            owner       <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
            resp_valid  <= 2'b00;
            resp_is_ack <= 1'b0;
            resp_data   <= '0;
            mc_type_out <= 3'b000;
            mc_id_out   <= '0;
            mc_addr_out <= '0;
            mc_data_out <= '0;
        end else begin
            free_vec    <= free_next;
            outstanding <= busy_cnt;
            if (resp_orphan) err_orphan <= 1'b1;

            resp_valid  <= resp_hit ? (owner[mc_id_in] ? 2'b10 : 2'b01) : 2'b00;
            resp_is_ack <= resp_hit && (mc_type_in == 3'b101);
            resp_data   <= (resp_hit && mc_type_in == 3'b110) ? mc_data_in : '0;

            if (grant_any) begin
                rr_ptr          <= ~grant_sel;
                owner[alloc_id] <= grant_sel;
                mc_type_out     <= req_write[grant_sel] ? 3'b001 : 3'b011;
                mc_id_out       <= alloc_id;
                mc_addr_out     <= req_addr[grant_sel];
                mc_data_out     <= req_write[grant_sel] ? req_data[grant_sel] : '0;
            end else begin
                mc_type_out <= 3'b000;
                mc_id_out   <= '0;
                mc_addr_out <= '0;
                mc_data_out <= '0;
            end
        end
    end

endmodule
